add8u_err_meter: RTL and testbench
==================================

# add8u_err_meter

Sequential error-characterisation engine for 8-bit unsigned approximate adders (A[7:0] + B[7:0] -> O[8:0]). It sweeps all 65536 operand pairs into an external combinational adder under test and reads back its 9-bit output. It compares each result against the exact sum and accumulates the library's standard metrics: absolute-error sum (MAE), worst-case error (WCE) with its operand pair, error count (EP) and squared-error sum (MSE). It is the consuming end of the adder interface and is used in on-FPGA characterisation of add8u_* variants.

## Interface
- No parameters; operand width fixed at 8, sum width at 9.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- dut_a  out  8  operand A driven to the adder under test (registered).
- dut_b  out  8  operand B driven to the adder under test (registered).
- dut_o  in  9  combinational result of the adder under test for the current dut_a/dut_b.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  high in DONE; held until the next start or reset.
- sum_abs_err  out  25  sum of |dut_o - (dut_a+dut_b)| over all pairs.
- sq_err_sum  out  34  sum of squared errors.
- err_count  out  17  number of pairs with nonzero error.
- max_err  out  9  largest absolute error.
- wce_a, wce_b  out  8 each  operands of the first pair, in sweep order, that reached max_err.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE + start=1: clear all accumulators, max_err, wce_a/b and the 16-bit index; go to RUN. start is ignored in RUN and FLUSH.
- Sweep order: index idx = {dut_b, dut_a}. dut_a increments fastest, from (0,0) to (255,255).
- RUN, every cycle:
  - Stage 1 registers err = |dut_o - ({1'b0,dut_a} + {1'b0,dut_b})| (9-bit unsigned), a valid bit, and the current operands.
  - idx then increments.
  - When idx == 0xFFFF is captured, go to FLUSH; idx wraps to 0.
- Stage 2 (one cycle after capture), when valid:
  - sum_abs_err += err.
  - sq_err_sum += err*err (18-bit product).
  - err_count += (err != 0).
  - If err > max_err (strict), update max_err and latch wce_a/wce_b. Ties keep the earlier pair.
- FLUSH: stage 2 accumulates the last pair; go to DONE.
- Widths are sized for the worst case (511 per pair × 65536 pairs); accumulators never saturate or wrap.
- Results are stable and readable in DONE. They are retained in IDLE only after reset, where they are zero.
- Every check is signed-safe: dut_o < exact and dut_o > exact both yield a positive err.

## Timing
- Reset (async assert, sync release): state IDLE, dut_a=dut_b=0, busy=0, done=0, all metric outputs 0, pipeline valid=0.
- Reset asserted mid-sweep aborts immediately to the reset values. No partial results are kept.
- Start accepted at edge E0: dut_a/dut_b=0 and busy=1 after E0.
- Pair k is captured at edge E(k+1) and accumulated at E(k+2).
- State is FLUSH after E65536, and DONE (busy=0, done=1) after E65537. A full sweep takes 65537 cycles from the start edge.
- dut_o must settle within one clk period of the dut_a/dut_b update. The path is register -> external adder -> err register.
- start in DONE restarts with the same timing and clears done at the start edge.

## Test plan
- Exact adder (dut_o = a+b): after 65537 cycles done=1; sum_abs_err=0, sq_err_sum=0, err_count=0, max_err=0, wce_a=wce_b=0.
- Constant +1 offset (dut_o = a+b+1): sum_abs_err=65536, sq_err_sum=65536, err_count=65536, max_err=1, wce=(0,0).
- Adder with O[0] forced 0: sum_abs_err=32768, sq_err_sum=32768, err_count=32768, max_err=1, wce=(1,0).
- Zero-output DUT (dut_o=0): sum_abs_err=16711680, sq_err_sum=4977295360, err_count=65535, max_err=510, wce=(255,255).
- start pulsed again at cycle 30000 of a sweep: ignored, done still exactly at cycle 65537. Then start in DONE clears done and the results reproduce identically.
- rst_n low at cycle 1000: busy, done and all outputs 0 asynchronously. A subsequent start completes the full sweep with correct totals.

Source files
------------

// File: rtl/add8u_err_meter_if.sv
// Adder-under-test bus: operands out to an external combinational 8-bit adder,
// 9-bit sum back.
//   master (meter): drives dut_a, dut_b; reads dut_o
//   slave  (adder): reads dut_a, dut_b; drives dut_o
interface add8u_err_meter_if;
  logic [7:0] dut_a;
  logic [7:0] dut_b;
  logic [8:0] dut_o;

  modport master (output dut_a, dut_b, input dut_o);
  modport slave  (input dut_a, dut_b, output dut_o);
endinterface

// File: rtl/add8u_err_meter.sv
// Error-characterisation engine for 8-bit unsigned approximate adders.
// Sweeps all 65536 operand pairs through the adder on bus, compares each
// result with the exact sum and accumulates MAE sum, squared-error sum,
// error count and worst-case error with its first operand pair.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        begin a sweep (honoured in IDLE/DONE only)
//   bus          adder bus (master): dut_a/dut_b registered, dut_o combinational
//   busy, done   RUN|FLUSH, DONE
//   sum_abs_err, sq_err_sum, err_count, max_err, wce_a, wce_b  results
module add8u_err_meter (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  add8u_err_meter_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic [24:0]              sum_abs_err,
  output logic [33:0]              sq_err_sum,
  output logic [16:0]              err_count,
  output logic [8:0]               max_err,
  output logic [7:0]               wce_a,
  output logic [7:0]               wce_b
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      state;
  logic [15:0] idx;      // {b, a}: a increments fastest
  logic        s1_vld;
  logic [8:0]  s1_err;
  logic [7:0]  s1_a;
  logic [7:0]  s1_b;

  logic [8:0]  exact;
  logic [8:0]  err_c;
  logic [17:0] sq_c;

  assign bus.dut_a = idx[7:0];
  assign bus.dut_b = idx[15:8];

  // Magnitude of the difference, both directions give a positive error.
  always_comb begin
    exact = {1'b0, bus.dut_a} + {1'b0, bus.dut_b};
    err_c = (bus.dut_o >= exact) ? (bus.dut_o - exact) : (exact - bus.dut_o);
    sq_c  = s1_err * s1_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      s1_vld      <= 1'b0;
      s1_err      <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sum_abs_err <= '0;
      sq_err_sum  <= '0;
      err_count   <= '0;
      max_err     <= '0;
      wce_a       <= '0;
      wce_b       <= '0;
    end else begin
      // Stage 2: accumulate the pair captured on the previous edge.
      if (s1_vld) begin
        sum_abs_err <= sum_abs_err + {16'd0, s1_err};
        sq_err_sum  <= sq_err_sum + {16'd0, sq_c};
        err_count   <= err_count + {16'd0, |s1_err};
        // Strict compare: ties keep the earlier pair in sweep order.
        if (s1_err > max_err) begin
          max_err <= s1_err;
          wce_a   <= s1_a;
          wce_b   <= s1_b;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            idx         <= '0;
            s1_vld      <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            sum_abs_err <= '0;
            sq_err_sum  <= '0;
            err_count   <= '0;
            max_err     <= '0;
            wce_a       <= '0;
            wce_b       <= '0;
          end
        end
        RUN: begin
          // Stage 1: capture error of the current pair, then advance.
          s1_err <= err_c;
          s1_a   <= bus.dut_a;
          s1_b   <= bus.dut_b;
          s1_vld <= 1'b1;
          idx    <= idx + 16'd1;
          if (idx == 16'hFFFF) state <= FLUSH;
        end
        FLUSH: begin
          s1_vld <= 1'b0;
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add8u_err_meter.sv
module tb_add8u_err_meter;

  typedef struct {
    logic [24:0] sae;
    logic [33:0] sq;
    logic [16:0] cnt;
    logic [8:0]  mx;
    logic [7:0]  wa;
    logic [7:0]  wb;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [24:0] sum_abs_err;
  logic [33:0] sq_err_sum;
  logic [16:0] err_count;
  logic [8:0]  max_err;
  logic [7:0]  wce_a, wce_b;
  int          mode = 0;
  int          total = 0;
  int          bad = 0;
  res_t        sb[$];

  add8u_err_meter_if bus();

  always #5 clk = ~clk;

  // Adder models: 0 exact, 1 +1, 2 O[0]=0, 3 zero, 4 mixed per b[7:6] quarter.
  function automatic logic [8:0] model_o(int m, logic [7:0] a, logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (m)
      0: return s;
      1: return s + 9'd1;
      2: return s & 9'h1FE;
      3: return 9'd0;
      default: begin
        case (b[7:6])
          2'd0: return s;
          2'd1: return s + 9'd1;
          2'd2: return s & 9'h1FE;
          default: return s ^ 9'h100;
        endcase
      end
    endcase
  endfunction

  assign bus.dut_o = model_o(mode, bus.dut_a, bus.dut_b);

  add8u_err_meter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .sum_abs_err(sum_abs_err), .sq_err_sum(sq_err_sum),
    .err_count(err_count), .max_err(max_err), .wce_a(wce_a), .wce_b(wce_b)
  );

  // Reference metrics over the first n pairs of the sweep.
  function automatic res_t model_sweep(int m, int n);
    res_t   r;
    longint sae, sq, cnt, e;
    int     mx, wa, wb;
    sae = 0; sq = 0; cnt = 0; mx = 0; wa = 0; wb = 0;
    for (int k = 0; k < n; k++) begin
      e = longint'(model_o(m, k[7:0], k[15:8])) - longint'(k % 256) - longint'(k / 256);
      if (e < 0) e = -e;
      sae += e;
      sq  += e * e;
      if (e != 0) cnt++;
      if (e > mx) begin mx = int'(e); wa = k % 256; wb = k / 256; end
    end
    r.sae = sae[24:0]; r.sq = sq[33:0]; r.cnt = cnt[16:0];
    r.mx = mx[8:0]; r.wa = wa[7:0]; r.wb = wb[7:0];
    return r;
  endfunction

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if ({bus.dut_b, bus.dut_a} !== 16'd0) begin bad++; $display("FAIL reset_ops got=%h exp=0", {bus.dut_b, bus.dut_a}); end
    total++; if ({sum_abs_err, sq_err_sum, err_count} !== '0) begin bad++; $display("FAIL reset_acc got=%0d/%0d/%0d exp=0", sum_abs_err, sq_err_sum, err_count); end
    total++; if ({max_err, wce_a, wce_b} !== '0) begin bad++; $display("FAIL reset_wce got=%0d/%0d/%0d exp=0", max_err, wce_a, wce_b); end
  endtask

  task automatic test_reset_midsweep();
    res_t p;
    mode = 3;
    p = model_sweep(3, 999);  // pairs 0..998 accumulated after E1000
    do_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0b exp=1", busy); end
    repeat (1000) @(posedge clk);
    #1;
    total++; if (sum_abs_err !== p.sae) begin bad++; $display("FAIL partial_sae got=%0d exp=%0d", sum_abs_err, p.sae); end
    total++; if (sq_err_sum !== p.sq) begin bad++; $display("FAIL partial_sq got=%0d exp=%0d", sq_err_sum, p.sq); end
    total++; if ({bus.dut_b, bus.dut_a} !== 16'd1000) begin bad++; $display("FAIL partial_idx got=%0d exp=1000", {bus.dut_b, bus.dut_a}); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_flags got=%b exp=00", {busy, done}); end
    total++; if ({bus.dut_b, bus.dut_a} !== 16'd0) begin bad++; $display("FAIL abort_ops got=%h exp=0", {bus.dut_b, bus.dut_a}); end
    total++; if ({sum_abs_err, sq_err_sum, err_count, max_err, wce_a, wce_b} !== '0) begin
      bad++; $display("FAIL abort_results got=%0d/%0d/%0d/%0d exp=0", sum_abs_err, sq_err_sum, err_count, max_err);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  // Full sweep with the mixed adder; a second start at cycle 30000 is ignored.
  task automatic test_sweep_mixed();
    res_t e;
    int   cyc;
    mode = 4;
    sb.push_back(model_sweep(4, 65536));
    do_start();
    cyc = 0;
    while (done !== 1'b1 && cyc < 70000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 30000) start = 1'b1;
      if (cyc == 30001) start = 1'b0;
      if (cyc == 1000) begin
        total++; if (bus.dut_a !== 8'd232 || bus.dut_b !== 8'd3) begin
          bad++; $display("FAIL sweep_order got=(%0d,%0d) exp=(232,3)", bus.dut_a, bus.dut_b);
        end
      end
      if (cyc == 65536) begin
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL flush_flags got=%b exp=10", {busy, done}); end
      end
    end
    total++; if (cyc !== 65537) begin bad++; $display("FAIL done_cycle got=%0d exp=65537", cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy got=%0b exp=0", busy); end
    if (sb.size() == 0) begin
      total++; bad++; $display("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      total++; if (sum_abs_err !== e.sae) begin bad++; $display("FAIL sae got=%0d exp=%0d", sum_abs_err, e.sae); end
      total++; if (sq_err_sum !== e.sq) begin bad++; $display("FAIL sq got=%0d exp=%0d", sq_err_sum, e.sq); end
      total++; if (err_count !== e.cnt) begin bad++; $display("FAIL cnt got=%0d exp=%0d", err_count, e.cnt); end
      total++; if (max_err !== e.mx) begin bad++; $display("FAIL max got=%0d exp=%0d", max_err, e.mx); end
      total++; if (wce_a !== e.wa || wce_b !== e.wb) begin
        bad++; $display("FAIL wce got=(%0d,%0d) exp=(%0d,%0d)", wce_a, wce_b, e.wa, e.wb);
      end
    end
    // Results hold in DONE.
    repeat (5) @(posedge clk);
    #1;
    total++; if (done !== 1'b1 || sum_abs_err !== e.sae) begin
      bad++; $display("FAIL done_hold got=%0b/%0d exp=1/%0d", done, sum_abs_err, e.sae);
    end
  endtask

  task automatic test_restart_in_done();
    mode = 1;
    do_start();
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL restart_flags got=%b exp=10", {busy, done}); end
    total++; if ({sum_abs_err, max_err, wce_a, wce_b} !== '0) begin
      bad++; $display("FAIL restart_clear got=%0d/%0d/%0d/%0d exp=0", sum_abs_err, max_err, wce_a, wce_b);
    end
    @(posedge clk); #1;
    total++; if (sum_abs_err !== 25'd0 || bus.dut_a !== 8'd1) begin
      bad++; $display("FAIL restart_e1 got=%0d/%0d exp=0/1", sum_abs_err, bus.dut_a);
    end
    repeat (9) @(posedge clk);
    #1;  // offset adder: pairs 0..8 accumulated, each err 1, first reaches max
    total++; if (sum_abs_err !== 25'd9 || err_count !== 17'd9 || max_err !== 9'd1 || {wce_a, wce_b} !== 16'd0) begin
      bad++; $display("FAIL restart_acc got=%0d/%0d/%0d/(%0d,%0d) exp=9/9/1/(0,0)", sum_abs_err, err_count, max_err, wce_a, wce_b);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midsweep();
    test_sweep_mixed();
    test_restart_in_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
